// File: rtl/aig_tt_evaluator.sv
// Streaming AIG-to-truth-table evaluator for 4-input functions.
// Accepts one AND-node record per handshake, then an output-literal record (in_last=1),
// and returns the 16-bit truth table of that literal with node count and error flag.
// Optional macro AIG_LEVEL_EN adds a per-node logic-level table and the out_level port.
module aig_tt_evaluator #(
  parameter int unsigned MAX_NODES = 16,
  parameter int unsigned IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W:0]   in_lit0,
  input  logic [IDX_W:0]   in_lit1,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_tt,
  output logic [IDX_W-1:0] out_nodes,
  output logic             out_err
`ifdef AIG_LEVEL_EN
  ,
  output logic [IDX_W-1:0] out_level
`endif
);

  typedef enum logic [0:0] {StAccept, StEmit} state_e;

  // Truth tables of const0, x0, x1, x2, x3 (bit k = f at input vector k)
  localparam logic [15:0] BaseTt [5] = '{16'h0000, 16'hAAAA, 16'hCCCC, 16'hF0F0, 16'hFF00};

  state_e           state_q, state_d;
  logic [15:0]      node_q [MAX_NODES];
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [15:0]      out_tt_q, out_tt_d;
  logic [IDX_W-1:0] out_nodes_q, out_nodes_d;
  logic             out_err_q, out_err_d;

  logic [IDX_W:0]   lit     [2];
  logic [IDX_W-1:0] lit_idx [2];
  logic [15:0]      lit_tt  [2];
  logic             lit_ok  [2];
  logic [IDX_W:0]   idx_limit;
  logic             rec_ok;
  logic             node_we;
  logic             res_ok;

`ifdef AIG_LEVEL_EN
  logic [IDX_W-1:0] level_q [MAX_NODES];
  logic [IDX_W-1:0] lit_lvl [2];
  logic [IDX_W-1:0] new_lvl;
  logic [IDX_W-1:0] out_level_q, out_level_d;
`endif

  assign lit[0] = in_lit0;
  assign lit[1] = in_lit1;

  // Resolve both fanin literals against the base tables and the stored nodes
  always_comb begin
    // Only indices below 5+cnt are defined; self and forward references fail here
    idx_limit = (IDX_W+1)'(cnt_q) + (IDX_W+1)'(5);
    for (int l = 0; l < 2; l++) begin
      lit_idx[l] = lit[l][IDX_W:1];
      lit_ok[l]  = {1'b0, lit_idx[l]} < idx_limit;
      lit_tt[l]  = 16'h0000;
`ifdef AIG_LEVEL_EN
      lit_lvl[l] = '0;
`endif
      for (int i = 0; i < 5; i++) begin
        if (lit_idx[l] == IDX_W'(i)) lit_tt[l] = BaseTt[i];
      end
      for (int i = 0; i < int'(MAX_NODES); i++) begin
        if (lit_idx[l] == IDX_W'(i + 5)) begin
          lit_tt[l] = node_q[i];
`ifdef AIG_LEVEL_EN
          lit_lvl[l] = level_q[i];
`endif
        end
      end
      if (lit[l][0]) lit_tt[l] = ~lit_tt[l];
    end
  end

  assign rec_ok  = lit_ok[0] && lit_ok[1] && (cnt_q != IDX_W'(MAX_NODES));
  assign node_we = (state_q == StAccept) && in_valid && !in_last && rec_ok;
  assign res_ok  = lit_ok[0] && !err_q;

`ifdef AIG_LEVEL_EN
  assign new_lvl = ((lit_lvl[0] > lit_lvl[1]) ? lit_lvl[0] : lit_lvl[1]) + IDX_W'(1);
`endif

  // Next-state, counter, sticky error and result capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_tt_d    = out_tt_q;
    out_nodes_d = out_nodes_q;
    out_err_d   = out_err_q;
`ifdef AIG_LEVEL_EN
    out_level_d = out_level_q;
`endif
    unique case (state_q)
      StAccept: begin
        if (in_valid) begin
          if (in_last) begin
            out_tt_d    = res_ok ? lit_tt[0] : 16'h0000;
            out_err_d   = !res_ok;
            out_nodes_d = cnt_q;
`ifdef AIG_LEVEL_EN
            out_level_d = res_ok ? lit_lvl[0] : '0;
`endif
            state_d     = StEmit;
          end else if (rec_ok) begin
            cnt_d = cnt_q + IDX_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StAccept;
        end
      end
      default: state_d = StAccept;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccept;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_tt_q    <= 16'h0000;
      out_nodes_q <= '0;
      out_err_q   <= 1'b0;
`ifdef AIG_LEVEL_EN
      out_level_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_tt_q    <= out_tt_d;
      out_nodes_q <= out_nodes_d;
      out_err_q   <= out_err_d;
`ifdef AIG_LEVEL_EN
      out_level_q <= out_level_d;
`endif
    end
  end

  // Node table is pure datapath; stale entries are never read because of the cnt bound
  always_ff @(posedge clk) begin
    if (node_we) begin
      for (int i = 0; i < int'(MAX_NODES); i++) begin
        if (cnt_q == IDX_W'(i)) begin
          node_q[i] <= lit_tt[0] & lit_tt[1];
`ifdef AIG_LEVEL_EN
          level_q[i] <= new_lvl;
`endif
        end
      end
    end
  end

  assign in_ready  = (state_q == StAccept);
  assign out_valid = (state_q == StEmit);
  assign out_tt    = out_tt_q;
  assign out_nodes = out_nodes_q;
  assign out_err   = out_err_q;
`ifdef AIG_LEVEL_EN
  assign out_level = out_level_q;
`endif

endmodule

// File: tb/tb_aig_tt_evaluator.sv
// Self-checking bench for aig_tt_evaluator: directed cases plus random AIGs,
// checked against a queue-based truth-table model built from the literal rules.
module tb_aig_tt_evaluator;
  localparam int MAX_NODES = 16;
  localparam int IDX_W     = 5;
  localparam int LW        = IDX_W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [LW-1:0]    in_lit0 = '0;
  logic [LW-1:0]    in_lit1 = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_tt;
  logic [IDX_W-1:0] out_nodes;
  logic             out_err;
`ifdef AIG_LEVEL_EN
  logic [IDX_W-1:0] out_level;
`endif

  aig_tt_evaluator #(
    .MAX_NODES(MAX_NODES),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_lit0(in_lit0),
    .in_lit1(in_lit1),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_tt(out_tt),
    .out_nodes(out_nodes),
    .out_err(out_err)
`ifdef AIG_LEVEL_EN
    ,
    .out_level(out_level)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: stored node functions and levels, plus the sticky error
  logic [15:0] m_tt [$];
  int          m_lvl [$];
  bit          m_err;
  logic [15:0] exp_tt_hold;

  function automatic logic [15:0] input_tt(input int idx);
    logic [15:0] r;
    r = '0;
    if (idx == 0) return r;
    for (int k = 0; k < 16; k++) r[k] = ((k >> (idx - 1)) & 1) != 0;
    return r;
  endfunction

  task automatic m_lookup(input logic [LW-1:0] lit, output bit ok, output logic [15:0] tt,
                          output int lvl);
    int idx;
    idx = int'(lit >> 1);
    ok  = idx < 5 + m_tt.size();
    tt  = '0;
    lvl = 0;
    if (ok && idx < 5) tt = input_tt(idx);
    else if (ok) begin
      tt  = m_tt[idx - 5];
      lvl = m_lvl[idx - 5];
    end
    if (lit[0]) tt = ~tt;
  endtask

  task automatic m_clear();
    m_tt.delete();
    m_lvl.delete();
    m_err = 0;
  endtask

  task automatic send(input logic [LW-1:0] l0, input logic [LW-1:0] l1, input logic last);
    int w;
    w = 0;
    @(negedge clk);
    in_lit0  = l0;
    in_lit1  = l1;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) check("in_ready_timeout", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic node(input logic [LW-1:0] l0, input logic [LW-1:0] l1);
    bit ok0, ok1;
    logic [15:0] t0, t1;
    int v0, v1;
    m_lookup(l0, ok0, t0, v0);
    m_lookup(l1, ok1, t1, v1);
    if (ok0 && ok1 && m_tt.size() < MAX_NODES) begin
      m_tt.push_back(t0 & t1);
      m_lvl.push_back(1 + ((v0 > v1) ? v0 : v1));
    end else begin
      m_err = 1;
    end
    send(l0, l1, 1'b0);
  endtask

  task automatic expect_last(input logic [LW-1:0] lit);
    bit ok, good;
    logic [15:0] t;
    int v;
    m_lookup(lit, ok, t, v);
    good = ok && !m_err;
    exp_tt_hold = good ? t : 16'h0000;
    send(lit, '0, 1'b1);
    check("out_valid", {31'b0, out_valid}, 1);
    check("out_tt", {16'b0, out_tt}, {16'b0, exp_tt_hold});
    check("out_nodes", {27'b0, out_nodes}, m_tt.size());
    check("out_err", {31'b0, out_err}, {31'b0, !good});
`ifdef AIG_LEVEL_EN
    check("out_level", {27'b0, out_level}, good ? v : 0);
`endif
  endtask

  task automatic release_out(input int hold);
    repeat (hold) begin
      @(negedge clk);
      check("hold_in_ready", {31'b0, in_ready}, 0);
      check("hold_out_valid", {31'b0, out_valid}, 1);
      check("hold_out_tt", {16'b0, out_tt}, {16'b0, exp_tt_hold});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_out_valid", {31'b0, out_valid}, 0);
    check("post_in_ready", {31'b0, in_ready}, 1);
    m_clear();
  endtask

  function automatic logic [LW-1:0] rand_lit();
    int idx;
    if ($urandom_range(0, 9) == 0) idx = $urandom_range(0, 31);
    else idx = $urandom_range(0, 4 + m_tt.size());
    return LW'((idx << 1) | int'($urandom_range(0, 1)));
  endfunction

  initial begin
    m_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_tt", {16'b0, out_tt}, 0);
    check("rst_out_nodes", {27'b0, out_nodes}, 0);
    check("rst_out_err", {31'b0, out_err}, 0);

    // Single AND node and its complement
    node(6'd2, 6'd4); expect_last(6'd10); check("and_tt", {16'b0, out_tt}, 32'h8888);
    release_out(0);
    node(6'd2, 6'd4); expect_last(6'd11); check("nand_tt", {16'b0, out_tt}, 32'h7777);
    release_out(1);

    // Primary inputs with no nodes
    expect_last(6'd1); check("not_const_tt", {16'b0, out_tt}, 32'hFFFF);
    release_out(0);
    expect_last(6'd8); check("x3_tt", {16'b0, out_tt}, 32'hFF00);
    release_out(0);

    // XOR built from three ANDs
    node(6'd2, 6'd4); node(6'd3, 6'd5); node(6'd11, 6'd13);
    expect_last(6'd14); check("xor_tt", {16'b0, out_tt}, 32'h6666);
`ifdef AIG_LEVEL_EN
    check("xor_level", {27'b0, out_level}, 2);
`endif
    release_out(0);

    // Forward reference, then recovery
    node(6'd2, 6'd12); expect_last(6'd2); check("fwd_err", {31'b0, out_err}, 1);
    release_out(0);
    node(6'd2, 6'd4); expect_last(6'd10); check("recover_err", {31'b0, out_err}, 0);
    release_out(0);

    // Self-loop on the first node slot
    node(6'd10, 6'd2); expect_last(6'd2);
    release_out(0);

    // Overflow of the node table
    for (int i = 0; i <= MAX_NODES; i++) node(6'd2, 6'd4);
    expect_last(6'd10);
    check("ovf_err", {31'b0, out_err}, 1);
    check("ovf_nodes", {27'b0, out_nodes}, MAX_NODES);
    release_out(0);

    // Backpressure, then reset in the middle of EMIT
    node(6'd2, 6'd4); expect_last(6'd10);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 0);
      check("bp_out_tt", {16'b0, out_tt}, 32'h8888);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    check("midrst_out_tt", {16'b0, out_tt}, 0);
    check("midrst_out_err", {31'b0, out_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
    check("postrst_in_ready", {31'b0, in_ready}, 1);
    node(6'd2, 6'd4); expect_last(6'd10); check("postrst_tt", {16'b0, out_tt}, 32'h8888);
    release_out(0);

    // Random AIGs
    for (int a = 0; a < 40; a++) begin
      int nrec;
      nrec = $urandom_range(0, MAX_NODES + 1);
      for (int r = 0; r < nrec; r++) node(rand_lit(), rand_lit());
      expect_last(rand_lit());
      release_out($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/aig_tt_evaluator.md
Name: aig_tt_evaluator

Overview:
- Streaming AIG-to-truth-table decoder for the 4-input exact-synthesis flow.
- Accepts an AIG one AND-node record per handshake, then a final output-literal record.
- Emits the 16-bit truth table of the output literal.
- Sits behind the netlist writer; used to check generated AIGs against their target NPN functions.

Parameters:
- MAX_NODES, 16, maximum number of AND nodes stored per AIG.
- IDX_W, 5, node-index width. Must satisfy 4+MAX_NODES <= 2^IDX_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  record valid.
- in_ready  output  1  evaluator can accept a record.
- in_lit0  input  IDX_W+1  fanin-0 literal, or the output literal when in_last=1.
- in_lit1  input  IDX_W+1  fanin-1 literal; ignored when in_last=1.
- in_last  input  1  record is the output-literal record.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_tt  output  16  truth table of the output literal; bit k = f(x3..x0 = k).
- out_nodes  output  IDX_W  number of AND nodes accepted for this AIG.
- out_err  output  1  AIG was malformed (see Behaviour).

Behaviour:
- Literal encoding: lit = {idx, c}. idx 0 = const0; idx 1..4 = x0..x3; idx 5.. = AND nodes in arrival order. c=1 complements.
- Base truth tables: const0 16'h0000, x0 16'hAAAA, x1 16'hCCCC, x2 16'hF0F0, x3 16'hFF00.
- Storage: node table of MAX_NODES x 16-bit registers, node counter cnt (0..MAX_NODES), sticky error flag err.
- States: ACCEPT and EMIT.
- ACCEPT:
  - in_ready=1, out_valid=0.
  - Handshake with in_last=0: tt = T(lit0) & T(lit1), where T resolves idx and applies c.
    - Record valid: write tt into node[cnt], cnt <= cnt+1.
    - Record invalid (either idx >= 5+cnt, i.e. forward or undefined reference, or cnt==MAX_NODES): err <= 1; table and cnt unchanged.
  - Handshake with in_last=1: out_tt <= T(lit0), or 16'h0000 if err is set or lit0 is invalid. out_err <= err or lit0 invalid. out_nodes <= cnt. Go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1. Outputs held stable until out_ready.
  - On out_valid&out_ready: cnt <= 0, err <= 0, go to ACCEPT.
  - Node contents need not be cleared.
- Latency: out_valid asserts on the cycle after the last-record handshake. A new AIG can be accepted on the cycle after the output handshake.
- Fanin evaluation is combinational from the node table. Each record is processed in one cycle, so full throughput is 1 record/cycle.
- A self-loop literal (idx == 5+cnt) counts as a forward reference and is an error.
- Reset: state=ACCEPT, cnt=0, err=0, out_valid=0, out_tt=0, out_nodes=0, out_err=0, in_ready=1 after release.
  - Reset mid-stream or in EMIT discards the partial AIG or pending result.
- in_ready depends only on state, never combinationally on in_valid. out_valid never depends on out_ready.

Optional Feature:
- Macro: AIG_LEVEL_EN.
- Defined:
  - Adds a per-node level table (IDX_W bits each) and output port out_level (IDX_W, output).
  - Level rules: inputs/const = 0; node level = 1 + max(level(lit0), level(lit1)).
  - out_level = level of the output literal; captured with out_tt; 0 on error; reset value 0.
- Not defined: no level table, no out_level port, and all other behaviour is identical.

Test Plan:
- Reset then single node AND(lit 2, lit 4), last lit 10 -> out_tt=16'h8888, out_nodes=1, out_err=0. Repeat with last lit 11 -> 16'h7777.
- No nodes, last lit 1 -> out_tt=16'hFFFF, out_nodes=0, out_valid exactly one cycle after handshake. Last lit 8 -> 16'hFF00.
- XOR x0^x1: AND(2,4), AND(3,5), AND(11,13), last lit 14 -> out_tt=16'h6666, out_nodes=3. With AIG_LEVEL_EN, out_level=2.
- Forward reference: AND(2,12) as first record, then last lit 2 -> out_err=1, out_tt=0, out_nodes=0. Next AIG AND(2,4) / last 10 -> 16'h8888, out_err=0 (error cleared).
- Overflow: MAX_NODES+1 valid records, then last lit 10 -> out_err=1, out_nodes=MAX_NODES.
- Backpressure/reset: hold out_ready=0 for 5 cycles -> in_ready=0 and out_tt stable throughout. Then assert rst_n=0 mid-EMIT -> out_valid=0, in_ready=1 after release, and the next AIG evaluates correctly.
